wb_bus_watchdog: RTL
====================

WB_BUS_WATCHDOG -- requirements
Module: wb_bus_watchdog

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 16, width of the Wishbone address.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, number of cycles allowed for slave ack (legal range 2..65535).
REQ-003 Parameter ERR_DATA, default 8'hEE, read data returned on a timed-out read.
REQ-004 i_clk  in  1  single system clock; all logic is on its rising edge.
REQ-005 i_rst_n  in  1  asynchronous, active-low reset.
REQ-006 i_m_cyc, i_m_stb, i_m_we  in  1 each  cycle, strobe and write enable from the RBCP-to-Wishbone bridge.
REQ-007 i_m_adr  in  ADDRESS_WIDTH  master address.
REQ-008 o_m_dat  out  8  read data to the master.
REQ-009 o_m_ack  out  1  ack to the master.
REQ-010 i_s_ack  in  1  OR of all slave acks.
REQ-011 i_s_dat  in  8  ack-gated OR of all slave read data.
REQ-012 o_s_stb  out  1  strobe forwarded to slaves.
REQ-013 i_clr  in  1  one-cycle pulse that clears the status counters.
REQ-014 o_to_cnt  out  16  saturating count of timeouts.
REQ-015 o_to_adr  out  ADDRESS_WIDTH  address of the most recent timeout.
REQ-016 o_to_we  out  1  we of the most recent timeout.
REQ-017 o_busy  out  1  high while in WAIT or ABORT.

Function
REQ-018 FSM states: IDLE, WAIT, ABORT, DONE.
REQ-019 In IDLE, i_m_cyc&i_m_stb moves to WAIT next cycle and loads the cycle counter with 0.
REQ-020 o_s_stb = i_m_stb & i_m_cyc combinationally in IDLE and WAIT; forced 0 in ABORT and DONE.
REQ-021 In WAIT the counter increments by 1 per cycle while i_s_ack=0.
REQ-022 i_s_ack=1 in IDLE or WAIT: o_m_ack=i_s_ack and o_m_dat=i_s_dat, combinational with zero added latency; the state moves to DONE.
REQ-023 When the counter reaches TIMEOUT_CYCLES-1 in WAIT with i_s_ack=0, the state moves to ABORT.
REQ-024 In ABORT, o_m_ack=1 for exactly one cycle and o_m_dat=ERR_DATA when the transaction is a read, 8'h00 when it is a write.
REQ-025 On entry to ABORT: o_to_adr<=i_m_adr, o_to_we<=i_m_we, and o_to_cnt increments, saturating at 16'hFFFF.
REQ-026 ABORT and DONE move to IDLE once i_m_stb=0 or i_m_cyc=0; otherwise they hold with o_m_ack=0.
REQ-027 i_s_ack arriving in ABORT or DONE (late ack) is discarded: no o_m_ack, no data, no state change.
REQ-028 i_m_cyc falling in WAIT aborts silently to IDLE with no ack and no counter update.
REQ-029 i_s_ack and timeout in the same cycle: the slave ack wins; no timeout is recorded.
REQ-030 i_clr zeroes o_to_cnt, o_to_adr and o_to_we next cycle.
REQ-031 i_clr coincident with a timeout: o_to_cnt becomes 1 and the address is captured.
REQ-032 o_m_ack is never high for two consecutive cycles.
REQ-033 Outside the ack cycles of REQ-022 and REQ-024, o_m_ack=0 and o_m_dat=8'h00.

Reset
REQ-034 i_rst_n=0 immediately forces the state to IDLE and clears the counter, o_to_cnt, o_to_adr and o_to_we to 0.
REQ-035 During reset, o_busy=0, and o_m_ack and o_m_dat are 0.
REQ-036 Reset mid-transaction drops the transaction; no ack is issued after release.
REQ-037 Reset release is synchronised (2-flop) to i_clk before it leaves the FSM.

Structure
REQ-038 The FSM state encoding and ERR_DATA default live in the shared package wb_pkg.
REQ-039 The saturating 16-bit status counter is a sub-module wb_sat_cnt16 (inc, clr, value).
REQ-040 The block sits between the RBCP-to-Wishbone bridge and the slave ack/data OR tree; no other logic is added.

Verification
REQ-041 Read; slave acks 3 cycles after stb with data 8'h5A -> o_m_ack one cycle coincident with slave ack, o_m_dat=8'h5A, o_to_cnt=0.
REQ-042 Read to an unmapped address 16'h0F00 with no slave ack and TIMEOUT_CYCLES=8 -> o_m_ack exactly 8 cycles after stb entry into WAIT, o_m_dat=8'hEE, o_to_cnt=1, o_to_adr=16'h0F00, o_to_we=0.
REQ-043 Slave ack at 12 cycles on a write with TIMEOUT_CYCLES=8 -> one ack at timeout with data 8'h00; the late ack is ignored; o_to_we=1.
REQ-044 Force o_to_cnt to 16'hFFFF, then trigger a timeout -> stays 16'hFFFF; i_clr pulse -> 0.
REQ-045 Reset asserted in WAIT cycle 4 -> o_busy=0 and o_m_ack=0 immediately; no ack after release.
REQ-046 Slave ack in the same cycle as timeout -> slave data delivered, o_to_cnt unchanged.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and defaults for the Wishbone bus watchdog.
// Holds the FSM encoding and the default error read data.
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ABORT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [7:0]  ERR_DATA_DEF = 8'hEE;
    localparam logic [15:0] CNT_MAX      = 16'hFFFF;

    function automatic logic busy_state(input state_t s);
        return (s == ST_WAIT) || (s == ST_ABORT);
    endfunction

endpackage

// File: rtl/wb_sat_cnt16.sv
// 16-bit saturating event counter with synchronous clear.
// A clear coincident with an increment leaves the count at one.
module wb_sat_cnt16
    import wb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        clr,
    output logic [15:0] value
);

    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= inc ? 16'd1 : 16'd0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign value = cnt_q;

endmodule

// File: rtl/wb_bus_watchdog.sv
// Wishbone ack watchdog between the RBCP bridge and the slave OR tree.
// Terminates unacked cycles with an error ack and records the last timeout.
module wb_bus_watchdog
    import wb_pkg::*;
#(
    parameter int          ADDRESS_WIDTH  = 16,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [7:0]  ERR_DATA       = ERR_DATA_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_m_cyc,
    input  logic                     i_m_stb,
    input  logic                     i_m_we,
    input  logic [ADDRESS_WIDTH-1:0] i_m_adr,
    output logic [7:0]               o_m_dat,
    output logic                     o_m_ack,
    input  logic                     i_s_ack,
    input  logic [7:0]               i_s_dat,
    output logic                     o_s_stb,
    input  logic                     i_clr,
    output logic [15:0]              o_to_cnt,
    output logic [ADDRESS_WIDTH-1:0] o_to_adr,
    output logic                     o_to_we,
    output logic                     o_busy
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  rst_sync;
    logic        rst_n;
    state_t      state;
    state_t      state_nxt;
    logic [15:0] wait_cnt;
    logic        abort_first;
    logic        req;
    logic        hit_idle;
    logic        hit_wait;
    logic        timeout;

    // Assertion is immediate; release reaches the FSM two edges later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    assign req      = i_m_cyc & i_m_stb;
    assign hit_idle = (state == ST_IDLE) & req & i_s_ack;
    assign hit_wait = (state == ST_WAIT) & i_m_cyc & i_s_ack;
    assign timeout  = (state == ST_WAIT) & i_m_cyc & ~i_s_ack
                    & (wait_cnt == TMO_LAST);

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            abort_first <= 1'b0;
        end else begin
            state       <= state_nxt;
            abort_first <= timeout;
            if (state == ST_IDLE) begin
                wait_cnt <= '0;
            end else if ((state == ST_WAIT) && !i_s_ack) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (hit_idle) begin
                    state_nxt = ST_DONE;
                end else if (req) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!i_m_cyc) begin
                    state_nxt = ST_IDLE;
                end else if (i_s_ack) begin
                    state_nxt = ST_DONE;
                end else if (timeout) begin
                    state_nxt = ST_ABORT;
                end
            end
            // Holding through the error-ack cycle keeps acks one cycle apart.
            ST_ABORT: begin
                if (!req && !abort_first) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (!req) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_s_stb = 1'b0;
        o_m_ack = 1'b0;
        o_m_dat = 8'h00;
        o_busy  = 1'b0;
        if (rst_n) begin
            o_busy = busy_state(state);
            unique case (state)
                ST_IDLE: begin
                    o_s_stb = req;
                    if (hit_idle) begin
                        o_m_ack = i_s_ack;
                        o_m_dat = i_s_dat;
                    end
                end
                ST_WAIT: begin
                    o_s_stb = req;
                    if (hit_wait) begin
                        o_m_ack = i_s_ack;
                        o_m_dat = i_s_dat;
                    end
                end
                ST_ABORT: begin
                    if (abort_first) begin
                        o_m_ack = 1'b1;
                        o_m_dat = i_m_we ? 8'h00 : ERR_DATA;
                    end
                end
                ST_DONE: begin
                    o_m_ack = 1'b0;
                end
                default: begin
                    o_m_ack = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            o_to_adr <= '0;
            o_to_we  <= 1'b0;
        end else if (timeout) begin
            o_to_adr <= i_m_adr;
            o_to_we  <= i_m_we;
        end else if (i_clr) begin
            o_to_adr <= '0;
            o_to_we  <= 1'b0;
        end
    end

    wb_sat_cnt16 u_to_cnt (
        .clk   (i_clk),
        .rst_n (rst_n),
        .inc   (timeout),
        .clr   (i_clr),
        .value (o_to_cnt)
    );

endmodule
